// File: rtl/math_pkg.sv
// Shared helpers for the math datapath blocks.
// Combinational only: width arithmetic and handshake qualification.
// No state, no backpressure of its own.
package math_pkg;

  // Accumulator / result width for an N-bit multiplier with G guard bits.
  function automatic int acc_w(input int n, input int g);
    return 2 * n + g;
  endfunction

  // A transfer happens on a channel only when both sides agree.
  function automatic logic fire(input logic vld, input logic rdy);
    return vld && rdy;
  endfunction

endpackage

// File: rtl/math_multiplier_carrysave.sv
// Unsigned N x N multiplier: carry-save reduction of partial products, final ripple add.
// Latency: purely combinational.
// Backpressure: none, no state.
module math_multiplier_carrysave #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] p_o
);

  logic [2*N-1:0] pp;
  logic [2*N-1:0] s_acc;
  logic [2*N-1:0] c_acc;
  logic [2*N-1:0] s_nxt;

  // Fold each partial product into a redundant (sum, carry) pair, resolve at the end.
  // Carries shifted past bit 2N-1 are multiples of 2^2N and the true product fits, so dropping them is exact.
  always_comb begin
    pp    = '0;
    s_acc = '0;
    c_acc = '0;
    s_nxt = '0;
    for (int i = 0; i < N; i++) begin
      pp    = b_i[i] ? ({{N{1'b0}}, a_i} << i) : '0;
      s_nxt = s_acc ^ c_acc ^ pp;
      c_acc = ((s_acc & c_acc) | (s_acc & pp) | (c_acc & pp)) << 1;
      s_acc = s_nxt;
    end
    p_o = s_acc + c_acc;
  end

endmodule

// File: rtl/math_multiplier_mac.sv
// Pipelined unsigned multiply-accumulate: operand reg -> product reg -> accumulator/result reg.
// Latency: last beat accepted at an edge appears on out_valid after the second following edge (3 registers).
// Backpressure: a single global enable stalls every stage while a result is held and not taken.
module math_multiplier_mac
  import math_pkg::*;
#(
  parameter int N = 4,
  parameter int G = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2*N+G-1:0] out_acc,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int ACC_W = acc_w(N, G);

  // Stage A: registered operands
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic             last_a_q, last_a_d, vld_a_q, vld_a_d;
  // Stage B: registered product
  logic [2*N-1:0]   p_q, p_d;
  logic             last_b_q, last_b_d, vld_b_q, vld_b_d;
  // Running group state
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  // Result register
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             en;
  logic [2*N-1:0]   p;
  logic [ACC_W:0]   sum_w;
  logic             ovf_next;

  math_multiplier_carrysave #(.N(N)) u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (p)
  );

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

  // Next state for the whole pipe; everything holds when the enable is low.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    last_a_d    = last_a_q;
    vld_a_d     = vld_a_q;
    p_d         = p_q;
    last_b_d    = last_b_q;
    vld_b_d     = vld_b_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    // One extra bit catches the carry out of the accumulator width.
    sum_w    = {1'b0, acc_q} + {{(G + 1){1'b0}}, p_q};
    ovf_next = ovf_q | sum_w[ACC_W];

    if (en) begin
      a_d      = in_a;
      b_d      = in_b;
      last_a_d = in_last;
      vld_a_d  = fire(in_valid, en);

      p_d      = p;
      last_b_d = last_a_q;
      vld_b_d  = vld_a_q;

      // Either nothing was held or the consumer is taking it this cycle.
      out_valid_d = 1'b0;

      if (vld_b_q) begin
        if (last_b_q) begin
          out_acc_d   = sum_w[ACC_W-1:0];
          out_ovf_d   = ovf_next;
          out_valid_d = 1'b1;
          acc_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = sum_w[ACC_W-1:0];
          ovf_d = ovf_next;
        end
      end
    end
  end

  // State registers, cleared asynchronously so a reset discards any partial group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      last_a_q    <= 1'b0;
      vld_a_q     <= 1'b0;
      p_q         <= '0;
      last_b_q    <= 1'b0;
      vld_b_q     <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      last_a_q    <= last_a_d;
      vld_a_q     <= vld_a_d;
      p_q         <= p_d;
      last_b_q    <= last_b_d;
      vld_b_q     <= vld_b_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_math_multiplier_mac.sv
// Bench for math_multiplier_mac (N=4, G=4): scenario tasks plus a result scoreboard.
// Expected group results are modelled when beats are accepted and checked as results are consumed.
// Output stalls are driven explicitly to exercise the global enable.
module tb_math_multiplier_mac;

  localparam int N     = 4;
  localparam int G     = 4;
  localparam int ACC_W = 2 * N + G;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  int   total;
  int   bad;
  int   n_pushed;
  int   n_seen;
  int   model_sum;
  exp_t sb[$];

  math_multiplier_mac #(.N(N), .G(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result consumer: each handshake pops the oldest expected group result.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got acc=%0d ovf=%0d, required no result", out_acc, out_ovf);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_seen++;
        if (out_acc !== e.acc || out_ovf !== e.ovf) begin
          bad++;
          $display("FAIL sb_result: got acc=%0d ovf=%0d, required acc=%0d ovf=%0d",
                   out_acc, out_ovf, e.acc, e.ovf);
        end
      end
    end
  end

  // Offer one beat starting at a falling edge; returns on the falling edge after it is accepted.
  task automatic send(input int a, input int b, input bit last);
    int g;
    in_a     = a[N-1:0];
    in_b     = b[N-1:0];
    in_last  = last;
    in_valid = 1'b1;
    #1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0d, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_sum += a * b;
    if (last) begin
      exp_t e;
      e.acc = model_sum[ACC_W-1:0];
      e.ovf = (model_sum >= (1 << ACC_W));
      sb.push_back(e);
      n_pushed++;
      model_sum = 0;
    end
  endtask

  task automatic wait_out_valid();
    int g;
    g = 0;
    #1;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL wait_out_valid: out_valid=%0d, required 1", out_valid);
    end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d, required 0", name, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_acc !== '0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got vld=%0d acc=%0d ovf=%0d rdy=%0d, required 0 0 0 1",
               out_valid, out_acc, out_ovf, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Acceptance edge is E1; result registers at E3, so out_valid is seen after E3 only.
  task automatic test_single_latency();
    out_ready = 1'b1;
    send(15, 15, 1'b1);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat_e1: out_valid=%0d, required 0", out_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat_e2: out_valid=%0d, required 0", out_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_acc !== 12'd225 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL lat_e3: got vld=%0d acc=%0d ovf=%0d, required 1 225 0",
               out_valid, out_acc, out_ovf);
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat_e4: out_valid=%0d, required 0", out_valid);
    end
    drain("single");
  endtask

  task automatic test_group();
    send(3, 5, 1'b0);
    send(7, 2, 1'b0);
    send(1, 1, 1'b1);
    send(2, 2, 1'b1);
    drain("group");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 19; i++) send(15, 15, i == 18);
    send(1, 1, 1'b1);
    drain("overflow");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(3, 5, 1'b0);
    send(7, 2, 1'b0);
    send(1, 1, 1'b1);
    wait_out_valid();
    in_a     = 4'd4;
    in_b     = 4'd4;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== 12'd30) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d rdy=%0d vld=%0d acc=%0d, required 0 1 30",
                 i, in_ready, out_valid, out_acc);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    send(4, 4, 1'b1);
    drain("backpressure");
  endtask

  task automatic test_bubbles();
    send(4, 4, 1'b0);
    repeat (2) @(negedge clk);
    send(2, 3, 1'b1);
    drain("bubbles");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 6; i++) send(i, 16 - i, 1'b1);
    drain("b2b");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(15, 15, 1'b0);
    send(15, 15, 1'b0);
    send(5, 5, 1'b1);
    wait_out_valid();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_acc !== '0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL arst_pending: got vld=%0d acc=%0d ovf=%0d rdy=%0d, required 0 0 0 1",
               out_valid, out_acc, out_ovf, in_ready);
    end
    sb.delete();
    n_pushed--;
    model_sum = 0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    send(15, 15, 1'b0);
    send(15, 15, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_acc !== '0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL arst_midgroup: got vld=%0d acc=%0d ovf=%0d, required 0 0 0",
               out_valid, out_acc, out_ovf);
    end
    model_sum = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(1, 2, 1'b1);
    drain("arst");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    n_pushed  = 0;
    n_seen    = 0;
    model_sum = 0;
    test_reset();
    test_single_latency();
    test_group();
    test_overflow();
    test_backpressure();
    test_bubbles();
    test_back_to_back();
    test_async_reset();
    repeat (5) @(negedge clk);
    total++;
    if (n_seen != n_pushed) begin
      bad++;
      $display("FAIL result_count: got %0d, required %0d", n_seen, n_pushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

endmodule
